// File: rtl/nios2_mult_pkg.sv
// Shared types for the iterative Nios II multiplier.
//   mode_e     : multiply mode, encoded exactly as the in_mode port
//   state_e    : sequencer states
//   prod_count : number of partial products the MUL state walks for a mode
// Optional feature macro: NIOS2_MULT_EARLY_LO_EN (low-word-only product walk for MUL).
package nios2_mult_pkg;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'd0,
    MODE_MULXUU = 2'd1,
    MODE_MULXSU = 2'd2,
    MODE_MULXSS = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_e;

  // Partial products needed for one operation with n slices per operand.
  function automatic int prod_count(input mode_e m, input int n);
`ifdef NIOS2_MULT_EARLY_LO_EN
    // The low word only sees products whose shift is below DATA_W.
    if (m == MODE_MUL) return n * (n + 1) / 2;
`else
    if (m == MODE_MUL) return n * n;
`endif
    return n * n;
  endfunction

endpackage

// File: rtl/nios2_mult_slice.sv
// Combinational SLICE_W x SLICE_W unsigned multiplier; maps onto one DSP block.
//   a_i, b_i : unsigned slices
//   p_o      : full 2*SLICE_W product
module nios2_mult_slice #(
  parameter int SLICE_W = 16
) (
  input  logic [SLICE_W-1:0]   a_i,
  input  logic [SLICE_W-1:0]   b_i,
  output logic [2*SLICE_W-1:0] p_o
);

  assign p_o = {{SLICE_W{1'b0}}, a_i} * {{SLICE_W{1'b0}}, b_i};

endmodule

// File: rtl/nios2_mult_iter.sv
// Iterative DATA_W x DATA_W multiplier sharing one SLICE_W hard multiplier.
// Walks all slice pairs into a 2*DATA_W accumulator, then applies the signed
// corrections for the high-word modes and presents the selected word.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : request handshake (ready only while idle)
//   in_src1, in_src2      : operands A, B
//   in_mode               : 0 MUL low, 1 MULXUU, 2 MULXSU, 3 MULXSS (high word)
//   out_valid/out_ready   : result handshake, result held until accepted
//   out_result            : selected product word (0 while not valid)
// Optional feature macro: NIOS2_MULT_EARLY_LO_EN -- MUL mode only walks the
// products that reach the low word and skips the correction cycle.
module nios2_mult_iter
  import nios2_mult_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result
);

  localparam int N  = DATA_W / SLICE_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(N * N + 1);
  localparam int AW = 2 * DATA_W;

  state_e            state_q, state_d;
  mode_e             mode_q,  mode_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [IW-1:0]     i_q, i_d, j_q, j_d;
  logic [KW-1:0]     k_q, k_d;

  logic [SLICE_W-1:0]   a_sl, b_sl;
  logic [2*SLICE_W-1:0] pp;
  logic [AW-1:0]        pp_sh;
  logic [AW-1:0]        corr_a, corr_b;
  logic                 j_wrap, last_pp;

  assign a_sl = a_q[int'(i_q) * SLICE_W +: SLICE_W];
  assign b_sl = b_q[int'(j_q) * SLICE_W +: SLICE_W];

  nios2_mult_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a_i (a_sl),
    .b_i (b_sl),
    .p_o (pp)
  );

  assign pp_sh = AW'(pp) << ((int'(i_q) + int'(j_q)) * SLICE_W);

  // Unsigned walk treats a negative operand X as X+2^W; subtracting the other
  // operand shifted by DATA_W removes that excess from the high word.
  assign corr_a = ((mode_q == MODE_MULXSU || mode_q == MODE_MULXSS) && a_q[DATA_W-1])
                  ? {b_q, {DATA_W{1'b0}}} : '0;
  assign corr_b = (mode_q == MODE_MULXSS && b_q[DATA_W-1])
                  ? {a_q, {DATA_W{1'b0}}} : '0;

  assign last_pp = (int'(k_q) == prod_count(mode_q, N) - 1);

  always_comb begin
    j_wrap = (int'(j_q) == N - 1);
`ifdef NIOS2_MULT_EARLY_LO_EN
    // Triangular walk: row i only covers j with i+j < N.
    if (mode_q == MODE_MUL) j_wrap = (int'(i_q) + int'(j_q) == N - 1);
`endif
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_src1;
          b_d     = in_src2;
          mode_d  = mode_e'(in_mode);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_q + pp_sh;
        k_d   = k_q + 1'b1;
        if (j_wrap) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        if (last_pp) begin
          state_d = CORR;
`ifdef NIOS2_MULT_EARLY_LO_EN
          if (mode_q == MODE_MUL) state_d = DONE;
`endif
        end
      end
      CORR: begin
        acc_d   = acc_q - corr_a - corr_b;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_MUL;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  always_comb begin
    out_result = '0;
    if (state_q == DONE)
      out_result = (mode_q == MODE_MUL) ? acc_q[DATA_W-1:0] : acc_q[AW-1:DATA_W];
  end

endmodule

// File: tb/tb_nios2_mult_iter.sv
module tb_nios2_mult_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_src1, in_src2;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int checks = 0;
  int errors = 0;

  nios2_mult_iter #(.DATA_W(32), .SLICE_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_for(input logic [1:0] m);
`ifdef NIOS2_MULT_EARLY_LO_EN
    if (m == 2'd0) return 3;
`endif
    return 5;
  endfunction

  // Independent reference: sign-extend per mode, multiply at 66 bits.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] m);
    logic signed [65:0] ea, eb, p;
    ea = (m >= 2'd2) ? {{34{a[31]}}, a} : {34'd0, a};
    eb = (m == 2'd3) ? {{34{b[31]}}, b} : {34'd0, b};
    p  = ea * eb;
    return (m == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Issue one request, wait for the result with a bounded wait, check latency
  // and value, then optionally complete the handshake.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    @(negedge clk);
    in_valid = 1'b1; in_src1 = a; in_src2 = b; in_mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(out_result), 64'(exp));
  endtask

  task automatic handshake(input string tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
    chk({tag, "_vld_after"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] m, input logic [31:0] exp);
    start_op(a, b, m);
    wait_result(tag, exp, lat_for(m));
    handshake(tag);
  endtask

  initial begin
    logic [31:0] held;
    reset = 1'b1; in_valid = 1'b0; in_src1 = '0; in_src2 = '0; in_mode = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    @(negedge clk); reset = 1'b0;

    // All-ones operands in every mode.
    run_op("ones_mul",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 32'h0000_0001);
    run_op("ones_mulxuu",32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, 32'hFFFF_FFFE);
    run_op("ones_mulxsu",32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 32'hFFFF_FFFF);
    run_op("ones_mulxss",32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000);

    // Most-negative operands.
    run_op("min_mulxuu", 32'h8000_0000, 32'h8000_0000, 2'd1, 32'h4000_0000);
    run_op("min_mulxss", 32'h8000_0000, 32'h8000_0000, 2'd3, 32'h4000_0000);
    run_op("min_mulxsu", 32'h8000_0000, 32'h8000_0000, 2'd2, 32'hC000_0000);

    // Cross-slice carries.
    run_op("mix_mul",    32'h0001_0003, 32'h0002_0005, 2'd0, 32'h000B_000F);
    run_op("mix_mulxuu", 32'h0001_0003, 32'h0002_0005, 2'd1, 32'h0000_0002);

    // Backpressure with an ignored request while busy.
    start_op(32'h0000_1234, 32'h0000_0100, 2'd0);
    @(negedge clk);
    in_valid = 1'b1; in_src1 = 32'hDEAD_BEEF; in_src2 = 32'h0000_0007; in_mode = 2'd1;
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("bp", 32'h0012_3400, lat_for(2'd0) - 1);
    held = out_result;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (c == 4); in_src1 = 32'h5; in_src2 = 32'h6; in_mode = 2'd3;
      @(posedge clk); #1;
      checks++;
      assert (out_valid === 1'b1 && in_ready === 1'b0 && out_result === held) else begin
        errors++;
        $error("FAIL bp_hold cycle=%0d observed v=%b r=%b res=%0h expected v=1 r=0 res=%0h",
               c, out_valid, in_ready, out_result, held);
      end
    end
    in_valid = 1'b0;
    handshake("bp");

    // Reset during MULXSS, then a clean MUL.
    start_op(32'hFFFF_FFF0, 32'h0000_0003, 2'd3);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk); reset = 1'b0;
    run_op("post_rst_mul", 32'd3, 32'd5, 2'd0, 32'h0000_000F);

    // Randomised operands and modes against the reference product.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, b;
      logic [1:0]  m;
      a = $urandom; b = $urandom; m = 2'($urandom_range(0, 3));
      if (n % 7 == 0) a = {1'b1, 31'($urandom)};
      start_op(a, b, m);
      wait_result("rand", ref_mul(a, b, m), lat_for(m));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      chk("rand_hold", 64'(out_result), 64'(ref_mul(a, b, m)));
      handshake("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
